// File: rtl/arithm2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : arithm2_arbiter
//  Purpose  : Round-robin sharing of one arithm2 datapath among NREQ
//             requesters, with a ce-stalled tag pipe tracking in-flight ops.
//  Revision : 1.0 - initial release
// ============================================================================
module arithm2_arbiter #(
    parameter int NREQ = 2,
    parameter int LAT  = 4,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*79-1:0]   req_ops,
    output logic                 dp_ce,
    output logic [17:0]          dp_A,
    output logic [7:0]           dp_B,
    output logic [11:0]          dp_C,
    output logic [7:0]           dp_D,
    output logic [13:0]          dp_E,
    output logic [18:0]          dp_F,
    input  logic [36:0]          dp_Y,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic [36:0]          res_data,
    output logic                 busy,
    output logic [15:0]          issued_cnt
);

    localparam int c_OPW = 79;

    logic [IDW-1:0]          r_ptr;
    logic [15:0]             r_cnt;
    logic [LAT:0]            r_tv;
    logic [LAT:0][IDW-1:0]   r_tid;
    logic [17:0]             r_A;
    logic [7:0]              r_B;
    logic [11:0]             r_C;
    logic [7:0]              r_D;
    logic [13:0]             r_E;
    logic [18:0]             r_F;

    logic                    w_ce;
    logic                    w_found;
    logic [IDW-1:0]          w_win;
    logic                    w_hs;
    logic [c_OPW-1:0]        w_sel;
    int                      w_idx;

    // A stalled head freezes everything, including the datapath itself.
    assign w_ce = ~(r_tv[LAT] & ~res_ready);

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(w_idx);
            end
        end
    end

    assign w_hs  = w_found & w_ce;
    assign w_sel = req_ops[c_OPW*int'(w_win) +: c_OPW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDW'(NREQ-1);
            r_cnt <= '0;
            r_tv  <= '0;
            r_tid <= '0;
            r_A   <= '0;
            r_B   <= '0;
            r_C   <= '0;
            r_D   <= '0;
            r_E   <= '0;
            r_F   <= '0;
        end else if (w_ce) begin
            for (int k = 1; k <= LAT; k++) begin
                r_tv[k]  <= r_tv[k-1];
                r_tid[k] <= r_tid[k-1];
            end
            r_tv[0] <= w_hs;
            if (w_hs) begin
                r_ptr    <= w_win;
                r_cnt    <= r_cnt + 16'd1;
                r_tid[0] <= w_win;
                r_A      <= w_sel[78:61];
                r_B      <= w_sel[60:53];
                r_C      <= w_sel[52:41];
                r_D      <= w_sel[40:33];
                r_E      <= w_sel[32:19];
                r_F      <= w_sel[18:0];
            end
        end
    end

    assign req_ready  = w_hs ? (NREQ'(1) << w_win) : '0;
    assign dp_ce      = w_ce;
    assign dp_A       = r_A;
    assign dp_B       = r_B;
    assign dp_C       = r_C;
    assign dp_D       = r_D;
    assign dp_E       = r_E;
    assign dp_F       = r_F;
    assign res_valid  = r_tv[LAT];
    assign res_id     = r_tid[LAT];
    assign res_data   = dp_Y;
    assign busy       = |r_tv;
    assign issued_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arithm2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arithm2_arbiter
//  Purpose  : Directed self-checking bench for arithm2_arbiter with a
//             ce-gated behavioural stand-in for the arithm2 datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arithm2_arbiter;

    localparam int NREQ = 2;
    localparam int LAT  = 4;
    localparam int IDW  = 1;
    localparam logic [36:0] c_T1_Y = 37'b1111111111111111101001100010010001000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*79-1:0]   req_ops;
    logic                 dp_ce;
    logic [17:0]          dp_A;
    logic [7:0]           dp_B;
    logic [11:0]          dp_C;
    logic [7:0]           dp_D;
    logic [13:0]          dp_E;
    logic [18:0]          dp_F;
    logic [36:0]          dp_Y;
    logic                 res_valid;
    logic                 res_ready;
    logic [IDW-1:0]       res_id;
    logic [36:0]          res_data;
    logic                 busy;
    logic [15:0]          issued_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    arithm2_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_ops(req_ops),
        .dp_ce(dp_ce), .dp_A(dp_A), .dp_B(dp_B), .dp_C(dp_C),
        .dp_D(dp_D), .dp_E(dp_E), .dp_F(dp_F), .dp_Y(dp_Y),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_data(res_data), .busy(busy), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in datapath: known answer for the reference vector, otherwise a
    // plain packing of A/C/B so every op carries a traceable result.
    function automatic logic [36:0] dp_func(input logic [17:0] a, input logic [7:0] b,
                                            input logic [11:0] c, input logic [7:0] d,
                                            input logic [13:0] e, input logic [18:0] f);
        if (a == 18'h00190 && b == 8'h0D && c == 12'hFAD && d == 8'h09 &&
            e == 14'h00C4 && f == 19'h7EEE1)
            return c_T1_Y;
        return {a, c, b[6:0]};
    endfunction

    logic [36:0] r_pipe [LAT];
    always @(posedge clk) begin
        if (dp_ce) begin
            r_pipe[0] <= dp_func(dp_A, dp_B, dp_C, dp_D, dp_E, dp_F);
            for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end
    assign dp_Y = r_pipe[LAT-1];

    function automatic logic [78:0] pack(input logic [17:0] a, input logic [7:0] b,
                                         input logic [11:0] c, input logic [7:0] d,
                                         input logic [13:0] e, input logic [18:0] f);
        return {a, b, c, d, e, f};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_ops   = '0;
        res_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check_eq("rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_dp_ce", 64'(dp_ce), 64'd1);
        check_eq("rst_cnt", 64'(issued_cnt), 64'd0);
        check_eq("rst_dp_A", 64'(dp_A), 64'd0);
        rst_n = 1'b1;
        tick();

        // Test 1 + 6: single op latency, value, busy window
        req_ops[78:0] = pack(18'h00190, 8'h0D, 12'hFAD, 8'h09, 14'h00C4, 19'h7EEE1);
        req_valid     = 2'b01;
        #1;
        check_eq("t1_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        check_eq("t1_dp_A", 64'(dp_A), 64'h190);
        check_eq("t1_dp_F", 64'(dp_F), 64'h7EEE1);
        for (int c = 1; c <= LAT + 1; c++) begin
            check_eq($sformatf("t1_res_valid_c%0d", c), 64'(res_valid), 64'(c == LAT + 1));
            check_eq($sformatf("t6_busy_c%0d", c), 64'(busy), 64'd1);
            check_eq($sformatf("t6_ce_c%0d", c), 64'(dp_ce), 64'd1);
            if (c == LAT + 1) begin
                check_eq("t1_res_id", 64'(res_id), 64'd0);
                check_eq("t1_res_data", 64'(res_data), 64'(c_T1_Y));
            end
            if (c < LAT + 1) tick();
        end
        tick();
        check_eq("t6_busy_off", 64'(busy), 64'd0);
        check_eq("t6_ce_idle", 64'(dp_ce), 64'd1);
        check_eq("t1_cnt", 64'(issued_cnt), 64'd1);

        // Test 2: alternating grants, in-order results at 1/cycle
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            if (k <= 6) begin
                if (k % 2 == 1) begin
                    req_ops[78:0]   = pack(18'(32'h100 + k), 8'h0, 12'h0, 8'h0, 14'h0, 19'h0);
                    req_ops[157:79] = pack(18'(32'h200 + k + 1), 8'h0, 12'h0, 8'h0, 14'h0, 19'h0);
                end
                req_valid = 2'b11;
                #1;
                check_eq($sformatf("t2_grant_%0d", k), 64'(req_ready), (k % 2 == 1) ? 64'h1 : 64'h2);
            end else begin
                req_valid = '0;
            end
            tick();
            if (k - LAT >= 1 && k - LAT <= 6) begin
                check_eq($sformatf("t2_res_valid_%0d", k - LAT), 64'(res_valid), 64'd1);
                check_eq($sformatf("t2_res_id_%0d", k - LAT), 64'(res_id), 64'((k - LAT) % 2 == 0));
                check_eq($sformatf("t2_res_data_%0d", k - LAT), 64'(res_data),
                         64'((((k - LAT) % 2 == 1) ? 32'h100 : 32'h200) + (k - LAT)) << 19);
            end else if (k - LAT > 6) begin
                check_eq("t2_res_end", 64'(res_valid), 64'd0);
            end
        end
        check_eq("t2_cnt", 64'(issued_cnt), 64'd6);

        // Test 3: fill pipe, stall 3 cycles, drain in order with a refill
        res_ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            req_ops[78:0] = pack(18'(32'h300 + n), 8'h0, 12'h0, 8'h0, 14'h0, 19'h0);
            req_valid     = 2'b01;
            tick();
        end
        req_ops[157:79] = pack(18'h3AA, 8'h0, 12'h0, 8'h0, 14'h0, 19'h0);
        req_valid       = 2'b10;
        #1;
        for (int s = 0; s < 3; s++) begin
            check_eq($sformatf("t3_stall_ce_%0d", s), 64'(dp_ce), 64'd0);
            check_eq($sformatf("t3_stall_rdy_%0d", s), 64'(req_ready), 64'd0);
            check_eq($sformatf("t3_stall_id_%0d", s), 64'(res_id), 64'd0);
            check_eq($sformatf("t3_stall_data_%0d", s), 64'(res_data), 64'h301 << 19);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check_eq("t3_refill_grant", 64'(req_ready), 64'h2);
        for (int n = 1; n <= 5; n++) begin
            check_eq($sformatf("t3_drain_valid_%0d", n), 64'(res_valid), 64'd1);
            check_eq($sformatf("t3_drain_data_%0d", n), 64'(res_data), 64'(32'h300 + n) << 19);
            tick();
            req_valid = '0;
        end
        check_eq("t3_refill_valid", 64'(res_valid), 64'd1);
        check_eq("t3_refill_id", 64'(res_id), 64'd1);
        check_eq("t3_refill_data", 64'(res_data), 64'h3AA << 19);
        tick();
        check_eq("t3_end_valid", 64'(res_valid), 64'd0);
        check_eq("t3_end_busy", 64'(busy), 64'd0);

        // Test 4: async reset with 3 ops in flight
        for (int n = 1; n <= 3; n++) begin
            req_ops[78:0] = pack(18'(32'h400 + n), 8'h0, 12'h0, 8'h0, 14'h0, 19'h0);
            req_valid     = 2'b01;
            tick();
        end
        req_valid = '0;
        check_eq("t4_busy_pre", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t4_rst_valid", 64'(res_valid), 64'd0);
        check_eq("t4_rst_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        begin
            int stale = 0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (res_valid) stale++;
            end
            check_eq("t4_no_stale", 64'(stale), 64'd0);
        end
        req_valid = 2'b11;
        #1;
        check_eq("t4_first_grant", 64'(req_ready), 64'h1);
        req_valid = '0;
        check_eq("t4_cnt", 64'(issued_cnt), 64'd0);

        // Test 5: counter wrap
        req_ops[78:0] = pack(18'h5, 8'h0, 12'h0, 8'h0, 14'h0, 19'h0);
        req_valid     = 2'b01;
        repeat (65535) tick();
        check_eq("t5_cnt_max", 64'(issued_cnt), 64'hFFFF);
        tick();
        check_eq("t5_cnt_wrap", 64'(issued_cnt), 64'd0);
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
